// File: rtl/slow_clock_sampler_pkg.sv
// Shared types, constants and elaboration helpers for slow_clock_sampler.
package slow_clock_sampler_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int DEF_CNT_W = 16;

  // Saturation value of a counter of the given width (supports widths up to 30).
  function automatic int sat_value(input int cnt_w);
    return (32'sd1 <<< cnt_w) - 32'sd1;
  endfunction

  function automatic bit timeout_in_range(input int timeout, input int cnt_w);
    return (timeout >= 32'sd1) && (timeout < sat_value(cnt_w));
  endfunction

endpackage

// File: rtl/slow_clock_sampler_if.sv
// Slow-clock input, capture data and derived status bundle.
interface slow_clock_sampler_if #(
  parameter int CNT_W = 16
) ();

  logic             slow_clk_in;
  logic             data_in;
  logic             rise_en;
  logic             fall_en;
  logic             data_out;
  logic             data_valid;
  logic             toggle_out;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             clk_lost;

  modport master (
    output slow_clk_in, data_in,
    input  rise_en, fall_en, data_out, data_valid, toggle_out,
    input  period, period_valid, clk_lost
  );

  modport slave (
    input  slow_clk_in, data_in,
    output rise_en, fall_en, data_out, data_valid, toggle_out,
    output period, period_valid, clk_lost
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus registered edge strobes.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_en,
  output logic fall_en
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("SYNC_STAGES must be at least 2");
  end

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] fill;
  logic                   hist;
  logic                   primed;
  logic                   sync_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // fill tracks when the chain holds real samples, so the history flop is
  // seeded from the first genuine value and never from the cleared chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r  <= '0;
      fill    <= '0;
      hist    <= 1'b0;
      primed  <= 1'b0;
      rise_en <= 1'b0;
      fall_en <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], d};
      fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1]) begin
        hist   <= sync_s;
        primed <= 1'b1;
      end
      rise_en <= primed &  sync_s & ~hist;
      fall_en <= primed & ~sync_s &  hist;
    end
  end

endmodule

// File: rtl/slow_clock_sampler.sv
// Turns an asynchronous slow clock into fast-domain strobes, captured data,
// period measurement and loss-of-clock status.
module slow_clock_sampler
  import slow_clock_sampler_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = 1000
) (
  input logic                 clk,
  input logic                 reset,
  slow_clock_sampler_if.slave bus
);

  if (!timeout_in_range(TIMEOUT, CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT must be in 1 .. 2**CNT_W-2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(sat_value(CNT_W));
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       rst_sync;
  logic             rst_int;
  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period_next;
  logic             rise;
  logic             timeout;

  // Asynchronous assertion, deassertion released on clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_int = rst_sync[1];

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst_int),
    .d      (bus.slow_clk_in),
    .rise_en(bus.rise_en),
    .fall_en(bus.fall_en)
  );

  assign rise        = bus.rise_en;
  assign timeout     = (counter == TIMEOUT_LAST);
  assign period_next = (counter == CNT_MAX) ? CNT_MAX : counter + CNT_W'(1);

  // Cycles since the last rising edge, saturating rather than wrapping.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      counter <= '0;
    end else if (rise) begin
      counter <= '0;
    end else if (counter != CNT_MAX) begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Lock state machine; a rising edge always beats a coincident timeout.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state            <= ACQUIRE;
      bus.data_out     <= 1'b0;
      bus.data_valid   <= 1'b0;
      bus.toggle_out   <= 1'b0;
      bus.period       <= '0;
      bus.period_valid <= 1'b0;
      bus.clk_lost     <= 1'b0;
    end else begin
      bus.data_valid <= rise;
      if (rise) begin
        bus.data_out   <= bus.data_in;
        bus.toggle_out <= ~bus.toggle_out;
      end
      case (state)
        ACQUIRE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            state            <= LOCKED;
            bus.period       <= period_next;
            bus.period_valid <= 1'b1;
          end else if (timeout) begin
            state            <= LOST;
            bus.clk_lost     <= 1'b1;
            bus.period_valid <= 1'b0;
          end
        end
        LOCKED: begin
          if (rise) begin
            bus.period <= period_next;
          end else if (timeout) begin
            state            <= LOST;
            bus.clk_lost     <= 1'b1;
            bus.period_valid <= 1'b0;
          end
        end
        LOST: begin
          if (rise) begin
            state        <= MEASURE;
            bus.clk_lost <= 1'b0;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

endmodule
